// File: rtl/afvip_rst_ctrl.sv
// Reset sequencer for the AFVIP APB subsystem: synchronizes intf_reset release,
// stretches reset, then releases NUM_DOMAINS reset outputs in order.
module afvip_rst_ctrl #(
    parameter int NUM_DOMAINS   = 3,
    parameter int ASSERT_CYCLES = 16,
    parameter int RELEASE_GAP   = 4,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                   clk,
    input  logic                   intf_reset,
    input  logic                   sw_rst_req,
    input  logic                   hold_req,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   rst_busy,
    output logic                   rst_done,
    output logic                   sw_rst_ack,
    output logic [1:0]             rst_cause
);

    localparam int MAX_CNT = (ASSERT_CYCLES > RELEASE_GAP) ? ASSERT_CYCLES : RELEASE_GAP;
    localparam int CW      = $clog2(MAX_CNT) + 1;
    localparam int IW      = $clog2(NUM_DOMAINS) + 1;

    localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST    = CW'(RELEASE_GAP - 1);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DOMAINS - 1);
    localparam logic [1:0]    CAUSE_POR   = 2'b01;
    localparam logic [1:0]    CAUSE_SW    = 2'b10;

    generate
        if (NUM_DOMAINS < 1) begin : g_bad_num_domains
            $error("afvip_rst_ctrl: NUM_DOMAINS must be >= 1");
        end
        if (ASSERT_CYCLES < 1) begin : g_bad_assert_cycles
            $error("afvip_rst_ctrl: ASSERT_CYCLES must be >= 1");
        end
        if (RELEASE_GAP < 1) begin : g_bad_release_gap
            $error("afvip_rst_ctrl: RELEASE_GAP must be >= 1");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync_stages
            $error("afvip_rst_ctrl: SYNC_STAGES must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_WAIT_SYNC = 2'd0,
        S_ASSERT    = 2'd1,
        S_RELEASE   = 2'd2,
        S_RUN       = 2'd3
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [CW-1:0]          r_cnt, w_cnt_nxt;
    logic [IW-1:0]          r_idx, w_idx_nxt;
    logic [NUM_DOMAINS-1:0] r_dom, w_dom_nxt;
    logic                   r_done, w_done_nxt;
    logic                   r_ack, w_ack_nxt;
    logic [1:0]             r_cause, w_cause_nxt;

    logic w_synced;
    logic w_assert_end;
    logic w_gap_end;
    logic w_last_dom;

    assign w_synced     = r_sync[SYNC_STAGES-1];
    assign w_assert_end = (r_state == S_ASSERT)  && !hold_req && (r_cnt == ASSERT_LAST);
    assign w_gap_end    = (r_state == S_RELEASE) && !hold_req && (r_cnt == GAP_LAST);
    assign w_last_dom   = (r_idx == IDX_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge intf_reset) begin
        if (intf_reset) begin
            r_state <= S_WAIT_SYNC;
            r_sync  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_dom   <= '1;
            r_done  <= 1'b0;
            r_ack   <= 1'b0;
            r_cause <= CAUSE_POR;
        end else begin
            r_state <= w_state_nxt;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], 1'b1};
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_dom   <= w_dom_nxt;
            r_done  <= w_done_nxt;
            r_ack   <= w_ack_nxt;
            r_cause <= w_cause_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
        w_state_nxt = r_state;
        unique case (r_state)
            S_WAIT_SYNC: if (w_synced) w_state_nxt = S_ASSERT;
            S_ASSERT:    if (w_assert_end) w_state_nxt = (NUM_DOMAINS == 1) ? S_RUN : S_RELEASE;
            S_RELEASE:   if (w_gap_end && w_last_dom) w_state_nxt = S_RUN;
            S_RUN:       if (sw_rst_req) w_state_nxt = S_ASSERT;
            default:     w_state_nxt = S_WAIT_SYNC;
        endcase
    end

    // Counters are frozen by hold_req only while sequencing; outputs are next-state registered.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dom_nxt   = r_dom;
        w_done_nxt  = 1'b0;
        w_ack_nxt   = 1'b0;
        w_cause_nxt = r_cause;
        unique case (r_state)
            S_WAIT_SYNC: begin
                w_cnt_nxt = '0;
                w_dom_nxt = '1;
            end
            S_ASSERT: begin
                if (w_assert_end) begin
                    w_dom_nxt[0] = 1'b0;
                    w_cnt_nxt    = '0;
                    w_idx_nxt    = IW'(1);
                    w_done_nxt   = (NUM_DOMAINS == 1);
                end else if (!hold_req) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RELEASE: begin
                if (w_gap_end) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (IW'(k) == r_idx) w_dom_nxt[k] = 1'b0;
                    end
                    w_idx_nxt  = r_idx + IW'(1);
                    w_cnt_nxt  = '0;
                    w_done_nxt = w_last_dom;
                end else if (!hold_req) begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_RUN: begin
                if (sw_rst_req) begin
                    w_dom_nxt   = '1;
                    w_cause_nxt = CAUSE_SW;
                    w_ack_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_cnt_nxt = '0;
                w_dom_nxt = '1;
            end
        endcase
    end

    assign domain_rst_o = r_dom;
    assign rst_busy     = (r_state != S_RUN);
    assign rst_done     = r_done;
    assign sw_rst_ack   = r_ack;
    assign rst_cause    = r_cause;

endmodule

// File: tb/tb_afvip_rst_ctrl.sv
// Scoreboard bench for afvip_rst_ctrl: a release-schedule model predicts every
// output change; a negedge monitor pops and compares whenever the DUT outputs change.
module tb_afvip_rst_ctrl;

    localparam int N = 3;
    localparam int A = 16;
    localparam int R = 4;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         intf_reset = 1'b1;
    logic         sw_rst_req = 1'b0;
    logic         hold_req = 1'b0;
    logic [N-1:0] domain_rst_o;
    logic         rst_busy, rst_done, sw_rst_ack;
    logic [1:0]   rst_cause;

    logic         s_dom, s_busy, s_done, s_ack;
    logic [1:0]   s_cause;

    always #5 clk = ~clk;

    afvip_rst_ctrl #(
        .NUM_DOMAINS(N), .ASSERT_CYCLES(A), .RELEASE_GAP(R), .SYNC_STAGES(S)
    ) dut (
        .clk(clk), .intf_reset(intf_reset), .sw_rst_req(sw_rst_req), .hold_req(hold_req),
        .domain_rst_o(domain_rst_o), .rst_busy(rst_busy), .rst_done(rst_done),
        .sw_rst_ack(sw_rst_ack), .rst_cause(rst_cause)
    );

    // Minimal variant: one domain, one stretch cycle, three-stage synchronizer.
    afvip_rst_ctrl #(
        .NUM_DOMAINS(1), .ASSERT_CYCLES(1), .RELEASE_GAP(1), .SYNC_STAGES(3)
    ) dut_small (
        .clk(clk), .intf_reset(intf_reset), .sw_rst_req(1'b0), .hold_req(1'b0),
        .domain_rst_o(s_dom), .rst_busy(s_busy), .rst_done(s_done),
        .sw_rst_ack(s_ack), .rst_cause(s_cause)
    );

    typedef struct packed {
        logic [N-1:0] dom;
        logic         busy;
        logic         done;
        logic         ack;
        logic [1:0]   cause;
    } out_t;

    typedef struct {
        int   cyc;
        out_t o;
    } ev_t;

    typedef enum {M_SYNC, M_SEQ, M_RUN} mode_t;

    localparam out_t RST_O = '{dom: '1, busy: 1'b1, done: 1'b0, ack: 1'b0, cause: 2'b01};

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    ev_t   sb_q[$];

    mode_t m_mode = M_SYNC;
    int    m_since = 0;
    int    m_act = 0;
    int    m_rel = 0;
    out_t  m_out = RST_O;
    out_t  mon_prev = RST_O;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] dom_after(input int released);
        logic [N-1:0] m;
        m = '1;
        for (int k = 0; k < N; k++) if (k < released) m[k] = 1'b0;
        return m;
    endfunction

    // Model: domain k drops once A + k*R un-held cycles have elapsed since ASSERT began.
    task automatic model_step();
        out_t nxt;
        cyc++;
        nxt      = m_out;
        nxt.done = 1'b0;
        nxt.ack  = 1'b0;
        if (intf_reset) begin
            m_mode  = M_SYNC;
            m_since = 0;
            nxt     = RST_O;
        end else begin
            case (m_mode)
                M_SYNC: begin
                    m_since++;
                    if (m_since == S + 1) begin
                        m_mode = M_SEQ;
                        m_act  = 0;
                        m_rel  = 0;
                    end
                end
                M_SEQ: begin
                    if (!hold_req) begin
                        m_act++;
                        if (m_act == A + m_rel * R) begin
                            m_rel++;
                            nxt.dom = dom_after(m_rel);
                            if (m_rel == N) begin
                                m_mode   = M_RUN;
                                nxt.busy = 1'b0;
                                nxt.done = 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    if (sw_rst_req) begin
                        m_mode    = M_SEQ;
                        m_act     = 0;
                        m_rel     = 0;
                        nxt.dom   = '1;
                        nxt.busy  = 1'b1;
                        nxt.ack   = 1'b1;
                        nxt.cause = 2'b10;
                    end
                end
            endcase
            if (nxt != m_out || nxt.done || nxt.ack) sb_q.push_back('{cyc: cyc, o: nxt});
        end
        m_out = nxt;
    endtask

    task automatic monitor_step();
        out_t cur;
        ev_t  ev;
        cur = {domain_rst_o, rst_busy, rst_done, sw_rst_ack, rst_cause};
        if (!intf_reset) begin
            while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
                check("sb_missed_event_cycle", cyc, sb_q[0].cyc);
                void'(sb_q.pop_front());
            end
            if (cur != mon_prev || cur.done || cur.ack) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_event", sb_q.size(), 1);
                end else begin
                    ev = sb_q.pop_front();
                    check("sb_out", cur, ev.o);
                    check("sb_cycle", cyc, ev.cyc);
                end
            end
        end
        mon_prev = cur;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        monitor_step();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    // Caller has just released intf_reset between edges; loop index e is the edge number.
    task automatic por_seq();
        for (int e = 1; e <= 30; e++) begin
            @(negedge clk);
            case (e)
                4:  check("small_dom_e4", s_dom, 1'b1);
                5: begin
                    check("small_dom_e5", s_dom, 1'b0);
                    check("small_done_e5", s_done, 1'b1);
                    check("small_busy_e5", s_busy, 1'b0);
                end
                6:  check("small_done_e6", s_done, 1'b0);
                18: check("dom_e18", domain_rst_o, 3'b111);
                19: check("dom_e19", domain_rst_o, 3'b110);
                23: check("dom_e23", domain_rst_o, 3'b100);
                27: begin
                    check("dom_e27", domain_rst_o, 3'b000);
                    check("done_e27", rst_done, 1'b1);
                    check("busy_e27", rst_busy, 1'b0);
                    check("cause_e27", rst_cause, 2'b01);
                end
                28: check("done_e28", rst_done, 1'b0);
                default: ;
            endcase
        end
    endtask

    task automatic sw_pulse();
        @(negedge clk);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        check("sw_ack", sw_rst_ack, 1'b1);
        check("sw_dom", domain_rst_o, 3'b111);
        check("sw_cause", rst_cause, 2'b10);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dom"}, domain_rst_o, 3'b111);
        check({tag, "_busy"}, rst_busy, 1'b1);
        check({tag, "_done"}, rst_done, 1'b0);
        check({tag, "_ack"}, sw_rst_ack, 1'b0);
        check({tag, "_cause"}, rst_cause, 2'b01);
    endtask

    initial begin
        int n;
        bit found;
        int unsigned r;

        repeat (3) @(negedge clk);
        #1;
        check_reset_outputs("por");
        check("por_small_dom", s_dom, 1'b1);
        #1 intf_reset = 1'b0;
        por_seq();

        // Software reset from RUN
        sw_pulse();
        repeat (30) @(negedge clk);

        // sw_rst_req held high through RELEASE: accepted at the first RUN edge
        sw_pulse();
        repeat (18) @(negedge clk);
        sw_rst_req = 1'b1;
        found = 1'b0;
        n = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(negedge clk);
            if (sw_rst_ack) begin
                found = 1'b1;
                n = i;
            end
        end
        sw_rst_req = 1'b0;
        check("held_sw_ack_delay", n, 7);
        repeat (30) @(negedge clk);

        // hold_req for 5 cycles mid-RELEASE delays the last release by 5
        sw_pulse();
        repeat (21) @(negedge clk);
        hold_req = 1'b1;
        repeat (5) @(negedge clk);
        check("hold_dom_frozen", domain_rst_o, 3'b100);
        hold_req = 1'b0;
        n = 0;
        for (int i = 1; i <= 20 && n == 0; i++) begin
            @(negedge clk);
            if (domain_rst_o == 3'b000) n = i;
        end
        check("hold_last_release_delay", n, 3);
        repeat (10) @(negedge clk);

        // Asynchronous intf_reset when only domain 0 is released
        sw_pulse();
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (domain_rst_o == 3'b110) found = 1'b1;
        end
        check("async_wait_found", found, 1'b1);
        #2 intf_reset = 1'b1;
        #1;
        check_reset_outputs("async");
        @(negedge clk);
        #2 intf_reset = 1'b0;
        por_seq();

        // Randomized phase, checked by the scoreboard
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            r = $urandom;
            sw_rst_req = (r[3:0] == 4'd0);
            hold_req   = (r[7:4] < 4'd3);
            if ($urandom_range(149, 0) == 0) begin
                #2 intf_reset = 1'b1;
                @(negedge clk);
                #2 intf_reset = 1'b0;
            end
        end
        sw_rst_req = 1'b0;
        hold_req   = 1'b0;
        repeat (60) @(negedge clk);
        check("sb_drain_empty", sb_q.size(), 0);
        check("drain_busy", rst_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
